// File: rtl/ashvin_viterbi.sv
// ashvin_viterbi: hard-decision rate-1/2 Viterbi decoder with 8-bit streaming I/O.
// The host loads one zero-terminated frame of coded symbol bytes (4 symbols per
// byte, earliest symbol in bits [1:0]) and pulses start. The block runs serial
// add-compare-select, traces back from state 0 and returns the decoded bits
// LSB-first, one byte per valid/ack handshake.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   ui_in    [0] byte_in strobe, [3] start, [4] byte_out ack
//   uio_in   coded symbol byte
//   uo_out   [0] byte_in_ready [1] byte_out_valid [2] overflow [3] busy
//            [4] frame_done [7:5] corrected-error count (optional) or 0
//   uio_out  decoded byte while presenting output, else 0
//   uio_oe   8'hFF while presenting output, else 0
//   ena      unused
// Optional feature macro: VITERBI_ERRCNT_EN (error count on uo_out[7:5]).
module ashvin_viterbi #(
    parameter int K        = 5,
    parameter int G0_OCT   = 'o23,
    parameter int G1_OCT   = 'o35,
    parameter int MAX_SYMS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);
    localparam int M   = K - 1;
    localparam int NS  = 1 << M;
    localparam int NB  = MAX_SYMS / 4;
    localparam int SW  = $clog2(MAX_SYMS);
    localparam int CW  = $clog2(MAX_SYMS + 1);
    localparam int OW  = ((MAX_SYMS + 7) / 8) * 8;
    localparam int OBW = (OW > 8) ? $clog2(OW / 8) : 1;
    localparam logic [K-1:0]  G0   = K'(G0_OCT);
    localparam logic [K-1:0]  G1   = K'(G1_OCT);
    localparam logic [CW-1:0] CMAX = CW'(MAX_SYMS);
    localparam logic [CW-1:0] CM   = CW'(M);

    typedef enum logic [2:0] {S_LOAD, S_ACS, S_TB, S_OUT, S_DONE} state_t;

    // Expected symbol for a full encoder register {state, in}.
    function automatic logic [1:0] enc(input logic [K-1:0] r);
        enc = {^(r & G0), ^(r & G1)};
    endfunction

    function automatic logic [1:0] hdist(input logic [1:0] a, input logic [1:0] b);
        hdist = {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, b};
        sat_add = s[8] ? 8'hFF : s[7:0];
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [SW-1:0]    step_q, step_d;
    logic [M-1:0]     sidx_q, sidx_d;
    logic             swap_q, swap_d;
    logic [M-1:0]     tbs_q, tbs_d;
    logic [OBW-1:0]   obyte_q, obyte_d;
    logic [OW-1:0]    dec_q, dec_d;
    logic [2:0]       err_d;
`ifdef VITERBI_ERRCNT_EN
    logic [2:0]       err_q;
`endif
    logic [7:0]       uo_d, uio_out_d, uio_oe_d;

    logic [7:0]       inb_q [NB];
    logic [7:0]       pm_q  [NS];
    logic [7:0]       nm_q  [NS];
    logic [NS-1:0]    surv_q [MAX_SYMS];

    logic             strobe_s, start_s, ack_s, ready_s, accept_s, ready_d_s;
    logic [7:0]       rx_byte_s, m0_s, m1_s, min_s;
    logic [1:0]       rx_s;
    logic [M-1:0]     p0_s, p1_s;
    logic             sel_s, sb_s, last_s;
    logic [CW-1:0]    nbits_s;

    wire unused_s = ^{ena, ui_in[7:5], ui_in[2:1]};

    assign strobe_s = ui_in[0];
    assign start_s  = ui_in[3];
    assign ack_s    = ui_in[4];
    assign ready_s  = ((state_q == S_LOAD) && (cnt_q < CMAX)) || (state_q == S_DONE);
    assign accept_s = strobe_s & ready_s;
    assign nbits_s  = cnt_q - CM;
    assign last_s   = (CW'(obyte_q) == ((nbits_s - CW'(1)) >> 3));

    // Datapath for one ACS butterfly half and one traceback step.
    always_comb begin
        rx_byte_s = inb_q[step_q[SW-1:2]];
        case (step_q[1:0])
            2'd0:    rx_s = rx_byte_s[1:0];
            2'd1:    rx_s = rx_byte_s[3:2];
            2'd2:    rx_s = rx_byte_s[5:4];
            default: rx_s = rx_byte_s[7:6];
        endcase
        // Predecessors of s' differ only in the oldest bit; {p, s'[0]} == {msb, s'}.
        p0_s  = {1'b0, sidx_q[M-1:1]};
        p1_s  = {1'b1, sidx_q[M-1:1]};
        m0_s  = sat_add(pm_q[p0_s], hdist(rx_s, enc({1'b0, sidx_q})));
        m1_s  = sat_add(pm_q[p1_s], hdist(rx_s, enc({1'b1, sidx_q})));
        sel_s = (m1_s < m0_s);
        min_s = sel_s ? m1_s : m0_s;
        sb_s  = surv_q[step_q][tbs_q];
    end

    // Next-state logic for the control FSM and the decoded-bit register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        step_d  = step_q;
        sidx_d  = sidx_q;
        swap_d  = swap_q;
        tbs_d   = tbs_q;
        obyte_d = obyte_q;
        dec_d   = dec_q;
`ifdef VITERBI_ERRCNT_EN
        err_d   = err_q;
`else
        err_d   = 3'd0;
`endif
        case (state_q)
            S_LOAD: begin
                if (start_s) begin
                    dec_d  = '0;
                    step_d = '0;
                    sidx_d = '0;
                    swap_d = 1'b0;
                    state_d = (cnt_q <= CM) ? S_DONE : S_ACS;
                end else if (strobe_s) begin
                    if (cnt_q < CMAX) begin
                        cnt_d = cnt_q + CW'(4);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_ACS: begin
                if (swap_q) begin
                    swap_d = 1'b0;
                    if (CW'(step_q) == (cnt_q - CW'(1))) begin
                        state_d = S_TB;
                        tbs_d   = '0;
                        // nm_q holds the final metrics; state 0 metric = errors corrected.
                        err_d   = (nm_q[0] > 8'd7) ? 3'd7 : nm_q[0][2:0];
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end else begin
                    sidx_d = sidx_q + M'(1);
                    swap_d = (sidx_q == M'(NS - 1));
                end
            end
            S_TB: begin
                if (CW'(step_q) < nbits_s) begin
                    dec_d[step_q] = tbs_q[0];
                end else begin
                    dec_d = dec_q;
                end
                tbs_d = {sb_s, tbs_q[M-1:1]};
                if (step_q == '0) begin
                    state_d = S_OUT;
                    obyte_d = '0;
                end else begin
                    step_d = step_q - SW'(1);
                end
            end
            S_OUT: begin
                if (ack_s) begin
                    if (last_s) begin
                        state_d = S_DONE;
                    end else begin
                        obyte_d = obyte_q + OBW'(1);
                    end
                end else begin
                    obyte_d = obyte_q;
                end
            end
            S_DONE: begin
                if (strobe_s) begin
                    state_d = S_LOAD;
                    cnt_d   = CW'(4);
                    ovf_d   = 1'b0;
                    err_d   = 3'd0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Output values computed from next state so the registered pins match the FSM.
    always_comb begin
        ready_d_s = ((state_d == S_LOAD) && (cnt_d < CMAX)) || (state_d == S_DONE);
        uo_d = {((state_d == S_OUT) || (state_d == S_DONE)) ? err_d : 3'd0,
                state_d == S_DONE,
                (state_d == S_ACS) || (state_d == S_TB),
                ovf_d,
                state_d == S_OUT,
                ready_d_s};
        if (state_d == S_OUT) begin
            uio_out_d = dec_d[{obyte_d, 3'b000} +: 8];
            uio_oe_d  = 8'hFF;
        end else begin
            uio_out_d = 8'h00;
            uio_oe_d  = 8'h00;
        end
    end

    // Control registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            step_q  <= '0;
            sidx_q  <= '0;
            swap_q  <= 1'b0;
            tbs_q   <= '0;
            obyte_q <= '0;
            dec_q   <= '0;
`ifdef VITERBI_ERRCNT_EN
            err_q   <= 3'd0;
`endif
            uo_out  <= 8'h01;
            uio_out <= 8'h00;
            uio_oe  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            step_q  <= step_d;
            sidx_q  <= sidx_d;
            swap_q  <= swap_d;
            tbs_q   <= tbs_d;
            obyte_q <= obyte_d;
            dec_q   <= dec_d;
`ifdef VITERBI_ERRCNT_EN
            err_q   <= err_d;
`endif
            uo_out  <= uo_d;
            uio_out <= uio_out_d;
            uio_oe  <= uio_oe_d;
        end
    end

    // Storage arrays: symbol bytes, path metrics and survivor bits (no reset needed).
    always_ff @(posedge clk) begin
        case (state_q)
            S_LOAD: begin
                if (start_s) begin
                    for (int i = 0; i < NS; i++) pm_q[i] <= (i == 0) ? 8'd0 : 8'hFF;
                end else if (accept_s) begin
                    inb_q[cnt_q[SW-1:2]] <= uio_in;
                end
            end
            S_DONE: begin
                if (accept_s) inb_q[0] <= uio_in;
            end
            S_ACS: begin
                if (swap_q) begin
                    for (int i = 0; i < NS; i++) pm_q[i] <= nm_q[i];
                end else begin
                    nm_q[sidx_q]           <= min_s;
                    surv_q[step_q][sidx_q] <= sel_s;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ashvin_viterbi.sv
module tb_ashvin_viterbi;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] ui0 = 8'h00, ui1 = 8'h00, ui2 = 8'h00;
    logic [7:0] uo0, uo1, uo2, uioo0, uioo1, uioo2, oe0, oe1, oe2;
    int n_checks = 0;
    int n_fail   = 0;
    int cur      = 0;

    always #5 clk = ~clk;

    ashvin_viterbi #(.K(5), .G0_OCT('o23), .G1_OCT('o35), .MAX_SYMS(32)) dut5 (
        .clk(clk), .rst(rst), .ui_in(ui0), .uio_in(uio_in),
        .uo_out(uo0), .uio_out(uioo0), .uio_oe(oe0), .ena(1'b1));
    ashvin_viterbi #(.K(3), .G0_OCT('o7), .G1_OCT('o5), .MAX_SYMS(32)) dut3 (
        .clk(clk), .rst(rst), .ui_in(ui1), .uio_in(uio_in),
        .uo_out(uo1), .uio_out(uioo1), .uio_oe(oe1), .ena(1'b1));
    ashvin_viterbi #(.K(7), .G0_OCT('o171), .G1_OCT('o133), .MAX_SYMS(32)) dut7 (
        .clk(clk), .rst(rst), .ui_in(ui2), .uio_in(uio_in),
        .uo_out(uo2), .uio_out(uioo2), .uio_oe(oe2), .ena(1'b1));

    function automatic int kk_f();
        case (cur) 0: return 5; 1: return 3; default: return 7; endcase
    endfunction
    function automatic int g0_f();
        case (cur) 0: return 'o23; 1: return 'o7; default: return 'o171; endcase
    endfunction
    function automatic int g1_f();
        case (cur) 0: return 'o35; 1: return 'o5; default: return 'o133; endcase
    endfunction
    function automatic logic [7:0] uo_f();
        case (cur) 0: return uo0; 1: return uo1; default: return uo2; endcase
    endfunction
    function automatic logic [7:0] uioo_f();
        case (cur) 0: return uioo0; 1: return uioo1; default: return uioo2; endcase
    endfunction
    function automatic logic [7:0] oe_f();
        case (cur) 0: return oe0; 1: return oe1; default: return oe2; endcase
    endfunction
    task automatic put_ui(input logic [7:0] v);
        case (cur) 0: ui0 = v; 1: ui1 = v; default: ui2 = v; endcase
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int to;
        logic [7:0] u;
        to = 0;
        u = uo_f();
        while (u[0] !== 1'b1 && to < 100) begin
            tick(); to++; u = uo_f();
        end
        n_checks++;
        if (u[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready got uo=%h want ready=1", u);
        end
        put_ui(8'h01);
        uio_in = b;
        tick();
        put_ui(8'h00);
    endtask

    task automatic pulse_start();
        logic [7:0] u;
        put_ui(8'h08);
        tick();
        put_ui(8'h00);
        u = uo_f();
        n_checks++;
        if (u[3] !== 1'b1 || u[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_start got uo=%h want busy=1 ready=0", u);
        end
    endtask

    // Encode, transmit, decode and read back one frame on the selected decoder.
    task automatic run_frame(input string name, input int nbits, input logic [31:0] data,
                             input int flip, input bit hold);
        int m, nbyt, t_all, n_dec, nout, to, st, r, g0, g1;
        logic [1:0] sym [64];
        logic [7:0] u, expb, got;
        logic [2:0] err_exp;
        logic bin;
        m = kk_f() - 1;
        g0 = g0_f();
        g1 = g1_f();
        nbyt = (nbits + m + 3) / 4;
        t_all = nbyt * 4;
        st = 0;
        for (int t = 0; t < t_all; t++) begin
            bin = (t < nbits) ? data[t] : 1'b0;
            r = (st << 1) | int'(bin);
            sym[t] = {^(r & g0), ^(r & g1)};
            st = r & ((1 << m) - 1);
        end
        if (flip >= 0) sym[flip / 2][flip % 2] = ~sym[flip / 2][flip % 2];
        for (int j = 0; j < nbyt; j++)
            send_byte({sym[4*j+3], sym[4*j+2], sym[4*j+1], sym[4*j]});
        pulse_start();
        to = 0;
        u = uo_f();
        while (u[1] !== 1'b1 && to < 20000) begin
            tick(); to++; u = uo_f();
        end
        n_checks++;
        if (u[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s valid_timeout got uo=%h want valid=1", name, u);
            return;
        end
        n_dec = t_all - m;
        nout = (n_dec + 7) / 8;
        for (int i = 0; i < nout; i++) begin
            expb = 8'h00;
            for (int bb = 0; bb < 8; bb++)
                if (8*i + bb < nbits) expb[bb] = data[8*i + bb];
            u = uo_f();
            got = uioo_f();
            n_checks++;
            if (got !== expb || u[1] !== 1'b1 || u[3] !== 1'b0 || oe_f() !== 8'hFF) begin
                n_fail++;
                $display("FAIL %s byte%0d got data=%h uo=%h oe=%h want data=%h valid=1 busy=0 oe=ff",
                         name, i, got, u, oe_f(), expb);
            end
            if (hold) begin
                repeat ($urandom_range(1, 3)) tick();
                got = uioo_f();
                u = uo_f();
                n_checks++;
                if (got !== expb || u[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s hold%0d got data=%h uo=%h want data=%h valid=1",
                             name, i, got, u, expb);
                end
            end
            put_ui(8'h10);
            tick();
            put_ui(8'h00);
        end
        err_exp = 3'd0;
`ifdef VITERBI_ERRCNT_EN
        err_exp = (flip >= 0) ? 3'd1 : 3'd0;
`endif
        u = uo_f();
        n_checks++;
        if (u !== {err_exp, 5'b10001} || oe_f() !== 8'h00 || uioo_f() !== 8'h00) begin
            n_fail++;
            $display("FAIL %s done_flags got uo=%h oe=%h data=%h want uo=%h oe=00 data=00",
                     name, u, oe_f(), uioo_f(), {err_exp, 5'b10001});
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            cur = d;
            n_checks++;
            if (uo_f() !== 8'h01 || uioo_f() !== 8'h00 || oe_f() !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_dut%0d got uo=%h data=%h oe=%h want 01 00 00",
                         d, uo_f(), uioo_f(), oe_f());
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        cur = 0;
    endtask

    task automatic test_short_frames();
        cur = 0;
        put_ui(8'h08);
        tick();
        put_ui(8'h00);
        n_checks++;
        if (uo_f() !== 8'h11) begin
            n_fail++;
            $display("FAIL empty_start got uo=%h want 11", uo_f());
        end
        send_byte(8'h00);
        put_ui(8'h08);
        tick();
        put_ui(8'h00);
        n_checks++;
        if (uo_f() !== 8'h11) begin
            n_fail++;
            $display("FAIL tail_only_start got uo=%h want 11", uo_f());
        end
    endtask

    task automatic test_known_bytes();
        logic [7:0] vals [11] = '{8'h00, 8'hB4, 8'hFF, 8'hAA, 8'h55, 8'h01,
                                  8'h80, 8'hFE, 8'hCC, 8'h0F, 8'hF0};
        cur = 0;
        foreach (vals[i]) run_frame($sformatf("k5_byte_%h", vals[i]), 8, {24'd0, vals[i]}, -1, 1'b0);
    endtask

    task automatic test_multibyte();
        cur = 0;
        run_frame("k5_acE2", 16, 32'h0000ACE2, -1, 1'b1);
        run_frame("k5_nibble", 4, 32'h0000000A, -1, 1'b0);
    endtask

    task automatic test_other_k();
        cur = 1;
        run_frame("k3_aaaaaa", 24, 32'h00AAAAAA, -1, 1'b0);
        run_frame("k3_ffffff", 24, 32'h00FFFFFF, -1, 1'b0);
        cur = 2;
        run_frame("k7_aaaaaa", 24, 32'h00AAAAAA, -1, 1'b0);
        run_frame("k7_ffffff", 24, 32'h00FFFFFF, -1, 1'b0);
    endtask

    task automatic test_bit_error();
        cur = 0;
        run_frame("k5_flip_5a", 8, 32'h0000005A, 12, 1'b0);
    endtask

    task automatic test_random();
        int m, nb, fl;
        logic [31:0] d;
        for (int it = 0; it < 12; it++) begin
            cur = $urandom_range(0, 2);
            m = kk_f() - 1;
            nb = $urandom_range(1, 32 - m);
            d = $urandom;
            if (nb < 32) d = d & ((32'h1 << nb) - 32'h1);
            fl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2 * (nb + m) - 1)) : -1;
            run_frame($sformatf("rand%0d_k%0d_n%0d", it, m + 1, nb), nb, d, fl, 1'b1);
        end
    endtask

    task automatic test_overflow_and_abort();
        logic [7:0] u;
        cur = 0;
        for (int j = 0; j < 8; j++) send_byte(8'($urandom));
        u = uo_f();
        n_checks++;
        if (u[0] !== 1'b0 || u[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_ready got uo=%h want ready=0 overflow=0", u);
        end
        put_ui(8'h01);
        uio_in = 8'h3C;
        tick();
        put_ui(8'h00);
        u = uo_f();
        n_checks++;
        if (u[2] !== 1'b1 || u[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow got uo=%h want overflow=1 ready=0", u);
        end
        pulse_start();
        repeat (5) tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (uo_f() !== 8'h01 || oe_f() !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_reset got uo=%h oe=%h want 01 00", uo_f(), oe_f());
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_short_frames();
        test_known_bytes();
        test_multibyte();
        test_other_k();
        test_bit_error();
        test_random();
        test_overflow_and_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
